// File: rtl/ltc2500_pkg.sv
// ltc2500_pkg
//   Shared definitions for the LTC2500 serial read-out path: frame/SCK
//   defaults and the read-out FSM state encoding, used by the capture top,
//   the serializer side and the controller.
package ltc2500_pkg;

  localparam int LTC_DATA_WIDTH = 32;
  localparam int LTC_SCK_DIV    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } ltc_state_t;

endpackage

// File: rtl/ltc2500_sdo_capture_ser2parallel.sv
// ser2parallel
//   MSB-first serial-to-parallel shift register. Each enabled clock shifts
//   i_ser_in into bit 0, so the first bit received ends up at the MSB.
// Ports
//   i_clk       system clock
//   i_rst       asynchronous active-high reset (clears the register)
//   i_shift_en  shift one bit in this cycle
//   i_ser_in    serial data bit
//   o_par_out   current register contents
module ser2parallel
  import ltc2500_pkg::*;
#(
  parameter int DATA_WIDTH = LTC_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_shift_en,
  input  logic                  i_ser_in,
  output logic [DATA_WIDTH-1:0] o_par_out
);

  logic [DATA_WIDTH-1:0] r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
    end else if (i_shift_en) begin
      r_shift <= {r_shift[DATA_WIDTH-2:0], i_ser_in};
    end
  end

  assign o_par_out = r_shift;

endmodule

// File: rtl/ltc2500_sdo_capture.sv
// ltc2500_sdo_capture
//   Receive-side read-out of the LTC2500 SDO link. A start pulse launches a
//   burst of DATA_WIDTH SCK cycles; SDO is sampled on the clk edge that
//   raises SCK and assembled MSB-first. The finished word goes into a
//   one-word holding buffer offered downstream with valid/ready. Overwriting
//   a word nobody took sets a sticky overrun flag.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOW   | SCK low half-period; sample SDO as it ends
//   HIGH  | SCK high half-period; last bit -> LATCH
//   LATCH | one cycle: move shift register into the holding buffer
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   start        frame start pulse (only honoured in IDLE)
//   ser_in       serial data from the ADC
//   sck          registered serial clock, idles low
//   busy         frame in progress
//   data_out     held word; data_valid holding buffer full
//   data_ready   consumer accepts data_out when valid & ready
//   overrun      sticky overwrite flag; overrun_clr clears it
module ltc2500_sdo_capture
  import ltc2500_pkg::*;
#(
  parameter int DATA_WIDTH = LTC_DATA_WIDTH,
  parameter int SCK_DIV    = LTC_SCK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ser_in,
  output logic                  sck,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int DIV_W = $clog2(SCK_DIV) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  ltc_state_t            r_state;
  ltc_state_t            w_next_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_sck;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  w_div_done;
  logic                  w_shift_en;
  logic                  w_latch;
  logic [DATA_WIDTH-1:0] w_shift_word;

  assign w_div_done = (r_div_cnt == DIV_LAST);

  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_LOW;
      end
      ST_LOW: begin
        if (w_div_done) begin
          w_shift_en   = 1'b1;
          w_next_state = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_div_done) begin
          w_next_state = (r_bit_cnt == LAST_BIT) ? ST_LATCH : ST_LOW;
        end
      end
      ST_LATCH: begin
        w_latch      = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Divider restarts on every state change so each half-period is exactly SCK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (r_state != w_next_state) begin
        r_div_cnt <= '0;
      end else if (r_state == ST_LOW || r_state == ST_HIGH) begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (r_state == ST_IDLE || r_state == ST_LATCH) begin
        r_bit_cnt <= '0;
      end else if (r_state == ST_HIGH && w_div_done && r_bit_cnt != LAST_BIT) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // SCK is high exactly while the FSM sits in HIGH, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sck <= 1'b0;
    else     r_sck <= (w_next_state == ST_HIGH);
  end

  ser2parallel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser2parallel (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_shift_en (w_shift_en),
    .i_ser_in   (ser_in),
    .o_par_out  (w_shift_word)
  );

  // A LATCH always refills the buffer, so valid stays set through a
  // same-cycle consume; only an unconsumed overwrite raises overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_latch) begin
        r_data  <= w_shift_word;
        r_valid <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end

      if (w_latch && r_valid && !data_ready) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign sck        = r_sck;
  assign busy       = (r_state != ST_IDLE);
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign overrun    = r_overrun;

endmodule
